// File: rtl/osc_bank.sv
// osc_bank: bank of NUM_VOICES phase counters with double-buffered dividers.
// Ports: clk, nrst (async low); wr_en/wr_addr/wr_data program a voice
// divider; voice_en gates each voice; count/tick/square are per-voice
// registered outputs. Optional OSC_HARD_SYNC_EN adds sync_in (hard sync).
module osc_bank #(
  parameter int NUM_VOICES = 4,
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [NUM_VOICES-1:0]       voice_en,
`ifdef OSC_HARD_SYNC_EN
  input  logic [NUM_VOICES-1:0]       sync_in,
`endif
  output logic [NUM_VOICES*WIDTH-1:0] count,
  output logic [NUM_VOICES-1:0]       tick,
  output logic [NUM_VOICES-1:0]       square
);

  logic [WIDTH-1:0]      cnt_q [NUM_VOICES];
  logic [WIDTH-1:0]      cnt_d [NUM_VOICES];
  logic [WIDTH-1:0]      act_q [NUM_VOICES];
  logic [WIDTH-1:0]      act_d [NUM_VOICES];
  logic [WIDTH-1:0]      pd_q  [NUM_VOICES];
  logic [WIDTH-1:0]      pd_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] pv_q, pv_d;
  logic [NUM_VOICES-1:0] tk_q, tk_d;
  logic [NUM_VOICES-1:0] sq_q, sq_d;
  logic [NUM_VOICES-1:0] hit_w;
  logic [NUM_VOICES-1:0] sync_w;

`ifdef OSC_HARD_SYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = '0;
`endif

  // Out-of-range addresses never match any voice.
  always_comb begin
    hit_w = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      hit_w[v] = wr_en && (wr_addr == ADDR_W'(v));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    pd_d  = pd_q;
    pv_d  = pv_q;
    sq_d  = sq_q;
    tk_d  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (act_q[v] == '0) begin
        // Silent: parked at 1, square low.
        cnt_d[v] = WIDTH'(1);
        sq_d[v]  = 1'b0;
        pv_d[v]  = 1'b0;
        if (hit_w[v]) begin
          act_d[v] = wr_data;
        end
      end else if (!voice_en[v]) begin
        // Disabled: phase frozen, writes apply at once.
        if (hit_w[v]) begin
          act_d[v] = wr_data;
          cnt_d[v] = WIDTH'(1);
          pv_d[v]  = 1'b0;
        end
      end else if (sync_w[v] || (cnt_q[v] >= act_q[v])) begin
        // Wrap (or hard sync): pick up the buffered divider.
        cnt_d[v] = WIDTH'(1);
        tk_d[v]  = 1'b1;
        sq_d[v]  = sync_w[v] ? 1'b0 : ~sq_q[v];
        pv_d[v]  = 1'b0;
        if (hit_w[v]) begin
          act_d[v] = wr_data;
        end else if (pv_q[v]) begin
          act_d[v] = pd_q[v];
        end
      end else begin
        cnt_d[v] = cnt_q[v] + WIDTH'(1);
        if (hit_w[v]) begin
          pd_d[v] = wr_data;
          pv_d[v] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cnt_q[v] <= WIDTH'(1);
        act_q[v] <= '0;
        pd_q[v]  <= '0;
      end
      pv_q <= '0;
      tk_q <= '0;
      sq_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cnt_q[v] <= cnt_d[v];
        act_q[v] <= act_d[v];
        pd_q[v]  <= pd_d[v];
      end
      pv_q <= pv_d;
      tk_q <= tk_d;
      sq_q <= sq_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign tick   = tk_q;
  assign square = sq_q;

endmodule

// File: tb/tb_osc_bank.sv
// tb_osc_bank: directed checks of osc_bank (4 voices) plus a
// 3-voice instance for out-of-range write addresses.
module tb_osc_bank;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  voice_en;
  logic [63:0] count;
  logic [3:0]  tick;
  logic [3:0]  square;
  logic        wr_en3;
  logic [2:0]  voice_en3;
  logic [47:0] count3;
  logic [2:0]  tick3;
  logic [2:0]  square3;
`ifdef OSC_HARD_SYNC_EN
  logic [3:0]  sync_in;
  logic [2:0]  sync_in3;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  osc_bank dut (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .voice_en (voice_en),
`ifdef OSC_HARD_SYNC_EN
    .sync_in  (sync_in),
`endif
    .count    (count),
    .tick     (tick),
    .square   (square)
  );

  osc_bank #(.NUM_VOICES(3)) dut3 (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en3),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .voice_en (voice_en3),
`ifdef OSC_HARD_SYNC_EN
    .sync_in  (sync_in3),
`endif
    .count    (count3),
    .tick     (tick3),
    .square   (square3)
  );

  function automatic logic [15:0] cv(int v);
    return count[v*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    voice_en = '0; wr_en3 = 1'b0; voice_en3 = '0;
`ifdef OSC_HARD_SYNC_EN
    sync_in = '0; sync_in3 = '0;
`endif
    #12;
    total++;
    if (count !== 64'h0001_0001_0001_0001)
      $display("FAIL reset_count got %h want 0001000100010001", count);
    else passed++;
    total++;
    if (tick !== 4'b0 || square !== 4'b0)
      $display("FAIL reset_tick_sq got %b/%b want 0000/0000", tick, square);
    else passed++;
    total++;
    if (count3 !== 48'h0001_0001_0001)
      $display("FAIL reset_count3 got %h want 000100010001", count3);
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) step();
    total++;
    if (count !== 64'h0001_0001_0001_0001 || tick !== 4'b0)
      $display("FAIL idle_silent got %h/%b want all 1 / 0", count, tick);
    else passed++;
  endtask

  task automatic test_ignore_addr();
    voice_en3 = 3'b111;
    wr_en3 = 1'b1; wr_addr = 2'd3; wr_data = 16'd2;
    step();
    wr_en3 = 1'b0;
    repeat (3) step();
    total++;
    if (count3 !== 48'h0001_0001_0001 || tick3 !== 3'b0)
      $display("FAIL ign_addr got %h/%b want 000100010001/000",
               count3, tick3);
    else passed++;
    wr_en3 = 1'b1; wr_addr = 2'd2; wr_data = 16'd2;
    step();
    wr_en3 = 1'b0;
    step();
    step();
    total++;
    if (tick3 !== 3'b100 || count3[47:32] !== 16'd1)
      $display("FAIL ign_ctrl got %b/%0d want 100/1",
               tick3, count3[47:32]);
    else passed++;
  endtask

  task automatic test_basic();
    int ec;
    logic es, et;
    voice_en = 4'b0001;
    wr(2'd0, 16'd4);
    total++;
    if (cv(0) !== 16'd1 || tick[0] !== 1'b0)
      $display("FAIL basic_load got %0d/%b want 1/0", cv(0), tick[0]);
    else passed++;
    ec = 1; es = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ec >= 4) begin
        ec = 1; es = ~es; et = 1'b1;
      end else begin
        ec++; et = 1'b0;
      end
      total++;
      if (cv(0) !== 16'(ec) || tick[0] !== et || square[0] !== es)
        $display("FAIL basic_seq%0d got %0d/%b/%b want %0d/%b/%b",
                 i, cv(0), tick[0], square[0], ec, et, es);
      else passed++;
    end
    total++;
    if (count[63:16] !== 48'h0001_0001_0001 || square[3:1] !== 3'b0)
      $display("FAIL basic_others got %h/%b want 000100010001/000",
               count[63:16], square[3:1]);
    else passed++;
  endtask

  task automatic test_pending();
    int exp_q [9];
    exp_q = '{4, 5, 1, 2, 3, 1, 2, 3, 1};
    voice_en = 4'b0010;
    wr(2'd1, 16'd5);
    step();
    total++;
    if (cv(1) !== 16'd2)
      $display("FAIL pend_pre got %0d want 2", cv(1));
    else passed++;
    wr(2'd1, 16'd3);
    total++;
    if (cv(1) !== 16'd3)
      $display("FAIL pend_wr got %0d want 3", cv(1));
    else passed++;
    for (int i = 0; i < 9; i++) begin
      step();
      total++;
      if (cv(1) !== 16'(exp_q[i]) || tick[1] !== (exp_q[i] == 1))
        $display("FAIL pend_seq%0d got %0d/%b want %0d/%b",
                 i, cv(1), tick[1], exp_q[i], exp_q[i] == 1);
      else passed++;
    end
  endtask

  task automatic test_wrap_write();
    voice_en = 4'b0100;
    wr(2'd2, 16'd3);
    step();
    step();
    total++;
    if (cv(2) !== 16'd3)
      $display("FAIL ww_pre got %0d want 3", cv(2));
    else passed++;
    wr(2'd2, 16'd6);
    total++;
    if (cv(2) !== 16'd1 || tick[2] !== 1'b1)
      $display("FAIL ww_wrap got %0d/%b want 1/1", cv(2), tick[2]);
    else passed++;
    for (int i = 2; i <= 6; i++) begin
      step();
      total++;
      if (cv(2) !== 16'(i) || tick[2] !== 1'b0)
        $display("FAIL ww_seq%0d got %0d/%b want %0d/0",
                 i, cv(2), tick[2], i);
      else passed++;
    end
    step();
    total++;
    if (cv(2) !== 16'd1 || tick[2] !== 1'b1)
      $display("FAIL ww_end got %0d/%b want 1/1", cv(2), tick[2]);
    else passed++;
  endtask

  task automatic test_div1();
    logic es;
    voice_en = 4'b1000;
    wr(2'd3, 16'd1);
    total++;
    if (cv(3) !== 16'd1 || tick[3] !== 1'b0 || square[3] !== 1'b0)
      $display("FAIL d1_load got %0d/%b/%b want 1/0/0",
               cv(3), tick[3], square[3]);
    else passed++;
    es = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      es = ~es;
      total++;
      if (tick[3] !== 1'b1 || square[3] !== es || cv(3) !== 16'd1)
        $display("FAIL d1_run%0d got %b/%b want 1/%b",
                 i, tick[3], square[3], es);
      else passed++;
    end
    wr(2'd3, 16'd0);
    total++;
    if (tick[3] !== 1'b1 || square[3] !== 1'b1)
      $display("FAIL d1_zero_wrap got %b/%b want 1/1", tick[3], square[3]);
    else passed++;
    step();
    total++;
    if (cv(3) !== 16'd1 || tick[3] !== 1'b0 || square[3] !== 1'b0)
      $display("FAIL d1_silent got %0d/%b/%b want 1/0/0",
               cv(3), tick[3], square[3]);
    else passed++;
    step();
    total++;
    if (tick[3] !== 1'b0 || square[3] !== 1'b0)
      $display("FAIL d1_stay got %b/%b want 0/0", tick[3], square[3]);
    else passed++;
  endtask

  task automatic test_disable();
    voice_en = 4'b0000;
    wr(2'd0, 16'd10);
    total++;
    if (cv(0) !== 16'd1)
      $display("FAIL dis_load got %0d want 1", cv(0));
    else passed++;
    voice_en = 4'b0001;
    for (int i = 2; i <= 6; i++) begin
      step();
      total++;
      if (cv(0) !== 16'(i))
        $display("FAIL dis_run%0d got %0d want %0d", i, cv(0), i);
      else passed++;
    end
    voice_en = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (cv(0) !== 16'd6 || tick[0] !== 1'b0 || square[0] !== 1'b1)
        $display("FAIL dis_hold%0d got %0d/%b/%b want 6/0/1",
                 i, cv(0), tick[0], square[0]);
      else passed++;
    end
    voice_en = 4'b0001;
    for (int i = 7; i <= 10; i++) begin
      step();
      total++;
      if (cv(0) !== 16'(i))
        $display("FAIL dis_resume%0d got %0d want %0d", i, cv(0), i);
      else passed++;
    end
    step();
    total++;
    if (cv(0) !== 16'd1 || tick[0] !== 1'b1 || square[0] !== 1'b0)
      $display("FAIL dis_wrap got %0d/%b/%b want 1/1/0",
               cv(0), tick[0], square[0]);
    else passed++;
  endtask

`ifdef OSC_HARD_SYNC_EN
  task automatic test_sync();
    voice_en = 4'b0001;
    repeat (10) step();
    total++;
    if (cv(0) !== 16'd1 || square[0] !== 1'b1)
      $display("FAIL sync_pre got %0d/%b want 1/1", cv(0), square[0]);
    else passed++;
    repeat (6) step();
    total++;
    if (cv(0) !== 16'd7)
      $display("FAIL sync_at7 got %0d want 7", cv(0));
    else passed++;
    sync_in = 4'b0001;
    step();
    sync_in = 4'b0000;
    total++;
    if (cv(0) !== 16'd1 || tick[0] !== 1'b1 || square[0] !== 1'b0)
      $display("FAIL sync_hit got %0d/%b/%b want 1/1/0",
               cv(0), tick[0], square[0]);
    else passed++;
    step();
    total++;
    if (cv(0) !== 16'd2 || tick[0] !== 1'b0)
      $display("FAIL sync_after got %0d/%b want 2/0", cv(0), tick[0]);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    voice_en = 4'b0010;
    wr(2'd1, 16'd7);
    total++;
    if (cv(1) !== 16'd2)
      $display("FAIL rm_pend got %0d want 2", cv(1));
    else passed++;
    #2;
    nrst = 1'b0;
    #1;
    total++;
    if (count !== 64'h0001_0001_0001_0001 || tick !== 4'b0 ||
        square !== 4'b0)
      $display("FAIL rm_async got %h/%b/%b want all 1/0000/0000",
               count, tick, square);
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
    voice_en = 4'b1111;
    repeat (8) step();
    total++;
    if (count !== 64'h0001_0001_0001_0001 || tick !== 4'b0)
      $display("FAIL rm_lost got %h/%b want all 1/0000", count, tick);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ignore_addr();
    test_basic();
    test_pending();
    test_wrap_write();
    test_div1();
    test_disable();
`ifdef OSC_HARD_SYNC_EN
    test_sync();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
